// File: rtl/i2c_pkg.sv
// Shared encodings for the single-byte I2C write master: FSM states,
// quarter-phase indices inside a bit cell, and the on-board LED slave address.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADDR  = 3'd2,
        AACK  = 3'd3,
        DATA  = 3'd4,
        DACK  = 3'd5,
        STOP  = 3'd6,
        DONE  = 3'd7
    } i2c_state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic [6:0] I2C_LED_ADDR = 7'b1010101;

endpackage

// File: rtl/i2c_qtr_tick.sv
// Quarter-SCL-period tick generator: counts 0..QTR-1 while enabled and pulses
// tick on the last count; held at zero while disabled.
module i2c_qtr_tick #(
    parameter int QTR = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CW'(QTR - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_master_tx.sv
// Single-byte I2C write master: START, address+W, ACK, data byte, ACK, STOP.
// SCL is push-pull; SDA is open-drain and read back through a 2-flop synchroniser.
module i2c_master_tx
    import i2c_pkg::*;
#(
    parameter int SYS_CLK_HZ = 100_000_000,
    parameter int I2C_HZ     = 100_000,
    parameter int QTR        = SYS_CLK_HZ / (4 * I2C_HZ)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic [6:0] i_addr,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_nack,
    output logic       SCL,
    inout  wire        SDA
);

    i2c_state_e state_q, state_d;
    logic [1:0] qtr_q, qtr_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       ack_q, ack_d;
    logic       nack_q, nack_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       scl_q, scl_d;
    logic       sda_oe_q, sda_oe_d;
    logic       sda_meta_q, sda_sync_q;
    logic       qtr_en, tick;

    assign qtr_en = (state_q != IDLE) && (state_q != DONE);

    i2c_qtr_tick #(.QTR(QTR)) u_qtr_tick (
        .clk   (clk),
        .reset (reset),
        .en    (qtr_en),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        ack_d   = ack_q;
        nack_d  = nack_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    shift_d = {i_addr, 1'b0};
                    data_d  = i_data;
                    nack_d  = 1'b0;
                    qtr_d   = Q0;
                    bit_d   = 3'd0;
                    state_d = START;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    // ACK slot is sampled at the end of the SCL-high first half
                    if ((qtr_q == Q2) && ((state_q == AACK) || (state_q == DACK))) begin
                        ack_d = sda_sync_q;
                        if (sda_sync_q) nack_d = 1'b1;
                    end
                    if (qtr_q == Q3) begin
                        case (state_q)
                            START: begin
                                bit_d   = 3'd0;
                                state_d = ADDR;
                            end
                            ADDR, DATA: begin
                                shift_d = {shift_q[6:0], 1'b0};
                                bit_d   = bit_q + 3'd1;
                                if (bit_q == 3'd7) state_d = (state_q == ADDR) ? AACK : DACK;
                            end
                            AACK: begin
                                if (ack_q) begin
                                    state_d = STOP;
                                end else begin
                                    shift_d = data_q;
                                    state_d = DATA;
                                end
                            end
                            DACK:    state_d = STOP;
                            STOP:    state_d = DONE;
                            default: state_d = state_q;
                        endcase
                    end
                end
            end
        endcase
    end

    // Bus and status outputs are decoded from the next state so they leave flops.
    always_comb begin
        busy_d   = (state_d != IDLE) && (state_d != DONE);
        done_d   = (state_d == DONE);
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            START: begin
                scl_d    = ~qtr_d[1];
                sda_oe_d = 1'b1;
            end
            ADDR, DATA: begin
                scl_d    = qtr_d[1];
                sda_oe_d = ~shift_d[7];
            end
            AACK, DACK: scl_d = qtr_d[1];
            STOP: begin
                scl_d    = (qtr_d != Q0);
                sda_oe_d = (qtr_d == Q0) || (qtr_d == Q1);
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            qtr_q      <= Q0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
            sda_meta_q <= SDA;
            sda_sync_q <= sda_meta_q;
        end
    end

    assign SDA    = sda_oe_q ? 1'b0 : 1'bz;
    assign SCL    = scl_q;
    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_nack = nack_q;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx: behavioural I2C slave decodes the bus into an event
// trace that is compared with a frame model built from the protocol rules.
module tb_i2c_master_tx;
    import i2c_pkg::*;

    localparam int QTR   = 4;
    localparam int LIMIT = 100 * QTR + 10;
    localparam int EV_S = 256, EV_P = 257, EV_ACK = 512, EV_NACK = 513;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_start = 1'b0;
    logic [6:0] i_addr = 7'h00;
    logic [7:0] i_data = 8'h00;
    logic       o_busy, o_done, o_nack, SCL;
    wire        SDA;

    logic       sl_drive = 1'b0;
    logic       sl_ack_addr = 1'b1;
    logic       sl_ack_data = 1'b1;

    assign SDA = sl_drive ? 1'b0 : 1'bz;
    pullup (SDA);

    always #5 clk = ~clk;

    i2c_master_tx #(.SYS_CLK_HZ(100_000_000), .I2C_HZ(6_250_000), .QTR(QTR)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_start (i_start),
        .i_addr  (i_addr),
        .i_data  (i_data),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_nack  (o_nack),
        .SCL     (SCL),
        .SDA     (SDA)
    );

    // ---------------- behavioural slave / bus monitor ----------------
    int         trace[$];
    int         exp_trace[$];
    logic [7:0] led = 8'h00;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    int         sl_bits = 0, sl_byte = 0;
    logic [7:0] sl_shift = 8'h00;
    logic       sl_match = 1'b0;
    int         done_cnt = 0;

    always @(negedge clk) begin
        logic sda_now;
        sda_now = (SDA === 1'b0) ? 1'b0 : 1'b1;
        if (o_done) done_cnt++;
        if (prev_scl && SCL) begin
            if (prev_sda && !sda_now) begin
                trace.push_back(EV_S); sl_bits = 0; sl_byte = 0; sl_drive = 1'b0;
            end else if (!prev_sda && sda_now) begin
                trace.push_back(EV_P); sl_bits = 0; sl_drive = 1'b0;
            end
        end else if (!prev_scl && SCL) begin
            if (sl_bits < 8) begin
                sl_shift = {sl_shift[6:0], sda_now};
                sl_bits++;
            end else if (sl_bits == 8) begin
                trace.push_back(sda_now ? EV_NACK : EV_ACK);
                sl_bits = 9;
            end
        end else if (prev_scl && !SCL) begin
            if (sl_bits == 8) begin
                trace.push_back(int'(sl_shift));
                if (sl_byte == 0) begin
                    sl_match = (sl_shift[7:1] == I2C_LED_ADDR) && !sl_shift[0];
                    sl_drive = sl_match && sl_ack_addr;
                end else begin
                    sl_drive = sl_match && sl_ack_data;
                    if (sl_drive) led = sl_shift;
                end
            end else if (sl_bits == 9) begin
                sl_drive = 1'b0; sl_bits = 0; sl_byte++;
            end
        end
        prev_scl = SCL;
        prev_sda = sda_now;
    end

    // ---------------- frame model ----------------
    logic exp_nack;
    int   exp_quarters;

    task automatic build_exp(input logic [6:0] a, input logic [7:0] d, input logic aa, input logic ad);
        logic ack_a, ack_d;
        ack_a = (a == I2C_LED_ADDR) && aa;
        ack_d = ad;
        exp_trace.delete();
        exp_trace.push_back(EV_S);
        exp_trace.push_back(int'({a, 1'b0}));
        exp_trace.push_back(ack_a ? EV_ACK : EV_NACK);
        if (ack_a) begin
            exp_trace.push_back(int'(d));
            exp_trace.push_back(ack_d ? EV_ACK : EV_NACK);
        end
        exp_trace.push_back(EV_P);
        exp_nack     = !ack_a || !ack_d;
        // START + address cell group + (data cell group) + STOP, 4 quarters per cell
        exp_quarters = 4 + 9 * 4 + (ack_a ? 9 * 4 : 0) + 4;
    endtask

    // ---------------- checking helpers ----------------
    int tests = 0, fails = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic trace_chk(input string nm);
        int bad;
        bad = 0;
        chk({nm, "_trace_len"}, trace.size(), exp_trace.size());
        foreach (exp_trace[i]) begin
            if (i >= trace.size()) bad++;
            else if (trace[i] != exp_trace[i]) bad++;
        end
        chk({nm, "_trace_bad_events"}, bad, 0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_txn(input logic [6:0] a, input logic [7:0] d);
        i_addr  = a;
        i_data  = d;
        i_start = 1'b1;
        trace.delete();
        @(negedge clk);
        i_start = 1'b0;
        chk("busy_after_accept", o_busy, 1);
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!o_done && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!o_done) chk("done_timeout", 0, 1);
    endtask

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        logic       aa;
        logic       ad;
        logic       exp_nack;
        int         exp_q;
        logic [7:0] exp_led;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n;
        logic [6:0] ra;
        logic [7:0] rd;
        logic       rad;
        int         dc;
        logic       seen_busy;

        vecs[0] = '{7'h55, 8'hA5, 1'b1, 1'b1, 1'b0, 80, 8'hA5};
        vecs[1] = '{7'h22, 8'h5A, 1'b1, 1'b1, 1'b1, 44, 8'hA5};
        vecs[2] = '{7'h55, 8'h3C, 1'b1, 1'b0, 1'b1, 80, 8'hA5};
        vecs[3] = '{7'h55, 8'h00, 1'b1, 1'b1, 1'b0, 80, 8'h00};
        vecs[4] = '{7'h55, 8'h77, 1'b0, 1'b1, 1'b1, 44, 8'h00};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_scl", SCL, 1);
        chk("rst_sda", (SDA === 1'b1), 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_nack", o_nack, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_scl", SCL, 1);

        // table-driven frames
        foreach (vecs[i]) begin
            sl_ack_addr = vecs[i].aa;
            sl_ack_data = vecs[i].ad;
            build_exp(vecs[i].addr, vecs[i].data, vecs[i].aa, vecs[i].ad);
            start_txn(vecs[i].addr, vecs[i].data);
            wait_done(n);
            chk("vec_latency", n, vecs[i].exp_q * QTR + 1);
            chk("vec_nack", o_nack, vecs[i].exp_nack);
            chk("vec_busy_at_done", o_busy, 0);
            trace_chk("vec");
            chk("vec_led", led, vecs[i].exp_led);
            @(negedge clk);
            chk("vec_done_one_cycle", o_done, 0);
            chk("vec_nack_hold", o_nack, vecs[i].exp_nack);
            repeat (2) @(negedge clk);
        end

        // i_start during the DONE cycle is ignored
        sl_ack_addr = 1'b1; sl_ack_data = 1'b1;
        start_txn(7'h55, 8'h11);
        wait_done(n);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        seen_busy = 1'b0;
        repeat (2 * QTR) begin
            @(negedge clk);
            if (o_busy) seen_busy = 1'b1;
        end
        chk("start_in_done_ignored", seen_busy, 0);

        // second i_start mid-ADDR is ignored
        build_exp(7'h55, 8'hA5, 1'b1, 1'b1);
        dc = done_cnt;
        start_txn(7'h55, 8'hA5);
        repeat (10 * QTR) @(negedge clk);
        i_addr = 7'h22; i_data = 8'hFF; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(n);
        chk("dup_latency", n + 10 * QTR + 1, 80 * QTR + 1);
        trace_chk("dup");
        chk("dup_led", led, 8'hA5);
        repeat (100) @(negedge clk);
        chk("dup_done_count", done_cnt - dc, 1);

        // back-to-back frames: second i_start on the cycle after o_done
        build_exp(7'h55, 8'h01, 1'b1, 1'b1);
        start_txn(7'h55, 8'h01);
        wait_done(n);
        chk("b2b1_latency", n, 80 * QTR + 1);
        trace_chk("b2b1");
        chk("b2b1_led", led, 8'h01);
        @(negedge clk);
        build_exp(7'h55, 8'h80, 1'b1, 1'b1);
        start_txn(7'h55, 8'h80);
        wait_done(n);
        chk("b2b2_latency", n, 80 * QTR + 1);
        chk("b2b2_nack", o_nack, 0);
        trace_chk("b2b2");
        chk("b2b2_led", led, 8'h80);
        repeat (3) @(negedge clk);

        // reset in the middle of the data byte
        start_txn(7'h55, 8'hC3);
        n = 0;
        while (!(sl_byte == 1 && sl_bits == 3) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reset_reached_data", (sl_byte == 1 && sl_bits == 3), 1);
        reset = 1'b1;
        #1;
        chk("mid_reset_scl", SCL, 1);
        chk("mid_reset_sda", (SDA === 1'b1), 1);
        chk("mid_reset_busy", o_busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        build_exp(7'h55, 8'h96, 1'b1, 1'b1);
        start_txn(7'h55, 8'h96);
        wait_done(n);
        chk("post_reset_latency", n, 80 * QTR + 1);
        chk("post_reset_nack", o_nack, 0);
        trace_chk("post_reset");
        chk("post_reset_led", led, 8'h96);
        repeat (2) @(negedge clk);

        // randomized frames against the model
        for (int k = 0; k < 10; k++) begin
            ra  = ($urandom_range(0, 1) == 1) ? I2C_LED_ADDR : 7'($urandom);
            rd  = 8'($urandom);
            rad = 1'($urandom_range(0, 1));
            sl_ack_addr = 1'b1;
            sl_ack_data = rad;
            build_exp(ra, rd, 1'b1, rad);
            start_txn(ra, rd);
            wait_done(n);
            chk("rnd_latency", n, exp_quarters * QTR + 1);
            chk("rnd_nack", o_nack, exp_nack);
            trace_chk("rnd");
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
